// File: rtl/unsigned_multiply_pkg.sv
// unsigned_multiply_pkg: shared widths and types for the unsigned multiplier
package unsigned_multiply_pkg;
    localparam int DEFAULT_WIDTH = 8;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    typedef logic [2*DEFAULT_WIDTH-1:0] product_t;
endpackage

// File: rtl/umul_pp_row.sv
// umul_pp_row: one shift-and-add partial-product row feeding the accumulator ripple
module umul_pp_row #(
    parameter int PW = 16
) (
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] opnd,
    input  logic          en,
    output logic [PW-1:0] sum
);
    assign sum = acc + (en ? opnd : '0);
endmodule

// File: rtl/unsigned_multiply.sv
// unsigned_multiply: registered full-precision unsigned multiplier.
// UMUL_INPUT_REG_EN adds an operand register stage (latency 2 instead of 1).
module unsigned_multiply
    import unsigned_multiply_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           dataa,
    input  logic [WIDTH-1:0]           datab,
    output logic [prod_width(WIDTH)-1:0] dataout
);
    localparam int PW = prod_width(WIDTH);

    logic [WIDTH-1:0] a_op, b_op;

`ifdef UMUL_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            a_op <= '0;
            b_op <= '0;
        end else begin
            a_op <= dataa;
            b_op <= datab;
        end
    end
`else
    assign a_op = dataa;
    assign b_op = datab;
`endif

    logic [WIDTH:0][PW-1:0] acc;
    assign acc[0] = '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        logic [PW-1:0] sh;
        assign sh = {{WIDTH{1'b0}}, a_op} << i;
        umul_pp_row #(.PW(PW)) u_row (
            .acc  (acc[i]),
            .opnd (sh),
            .en   (b_op[i]),
            .sum  (acc[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) dataout <= '0;
        else       dataout <= acc[WIDTH];
    end
endmodule

// File: tb/tb_unsigned_multiply.sv
// tb_unsigned_multiply: directed and random checks against an arithmetic reference model
module tb_unsigned_multiply;
    import unsigned_multiply_pkg::*;

`ifdef UMUL_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] dataa = '0, datab = '0;
    product_t dataout;

    int total = 0;
    int bad = 0;
    int ha[$], hb[$];
    bit hr[$];

    unsigned_multiply #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataa   (dataa),
        .datab   (datab),
        .dataout (dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge after one rising edge.
    task automatic tick(input int a, input int b, input bit r);
        dataa = 8'(a);
        datab = 8'(b);
        reset = r;
        @(posedge clk);
        ha.push_back(a);
        hb.push_back(b);
        hr.push_back(r);
        @(negedge clk);
    endtask

    // Output after the latest edge: zero if reset hit the pipeline window, else the product LAT-1 edges back.
    function automatic logic [31:0] model();
        int n = ha.size();
        for (int k = n - LAT; k < n; k++)
            if (hr[k]) return 0;
        return 32'(ha[n-LAT] * hb[n-LAT]);
    endfunction

    task automatic hold_check(input string tag, input int a, input int b, input int exp);
        tick(a, b, 0);
        tick(a, b, 0);
        check(tag, 32'(dataout), 32'(exp));
    endtask

    initial begin
        int pa[3] = '{3, 7, 250};
        int pb[3] = '{5, 9, 4};
        int pe[3] = '{15, 63, 1000};
        @(negedge clk);
        for (int i = 0; i < 5; i++) tick(0, 0, 1);
        check("reset_hold", 32'(dataout), 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("post_reset", 32'(dataout), 0);
        check("no_x", 32'($isunknown(dataout)), 0);

        hold_check("max", 255, 255, 65025);
        hold_check("zero_a", 0, 173, 0);
        hold_check("one_x200", 1, 200, 200);
        hold_check("carry", 128, 2, 256);
        hold_check("x_one", 255, 1, 255);
        hold_check("sq16", 16, 16, 256);

        // back-to-back products must emerge on consecutive cycles
        for (int i = 0; i < 3 + LAT - 1; i++) begin
            if (i < 3) tick(pa[i], pb[i], 0);
            else       tick(0, 0, 0);
            if (i >= LAT - 1) check("b2b", 32'(dataout), 32'(pe[i-LAT+1]));
            check("b2b_model", 32'(dataout), model());
        end

        tick(20, 30, 0);
        tick(40, 50, 0);
        tick(60, 70, 1);
        check("mid_reset", 32'(dataout), 0);
        check("mid_reset_model", 32'(dataout), model());
        hold_check("after_reset", 12, 12, 144);

        for (int i = 0; i < 100; i++) begin
            int a = int'($urandom_range(255));
            int b = int'($urandom_range(255));
            hold_check("rand", a, b, a * b);
            check("rand_model", 32'(dataout), model());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
